// File: rtl/regfile_pkg.sv
// Shared register-file types used by the issue scoreboard.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      vld;
        logic      rs1_used;
        reg_addr_t rs1_addr;
        logic      rs2_used;
        reg_addr_t rs2_addr;
        logic      rd_wren;
        reg_addr_t rd_addr;
    } issue_req_t;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-writer counter: inc/dec cancel, clr wins over both.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_nonzero,
    output logic             o_at_max
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_nonzero = |r_cnt;
    assign o_at_max  = &r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard: counts in-flight writers per register and stalls on hazards.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_issue_vld,
    input  logic                i_issue_rs1_used,
    input  logic [4:0]          i_issue_rs1_addr,
    input  logic                i_issue_rs2_used,
    input  logic [4:0]          i_issue_rs2_addr,
    input  logic                i_issue_rd_wren,
    input  logic [4:0]          i_issue_rd_addr,
    input  logic                i_wb_rd_wren,
    input  logic [4:0]          i_wb_rd_addr,
    input  logic                i_flush,
    output logic                o_stall,
    output logic                o_issue_ack,
    output logic [NUM_REGS-1:0] o_busy_vec,
    output logic                o_err
);

    issue_req_t          w_req;
    logic [NUM_REGS-1:0] w_nonzero;
    logic [NUM_REGS-1:0] w_at_max;
    logic [NUM_REGS-1:0] w_wb_hit;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic                w_src_hz;
    logic                w_ovf;
    logic                w_stall;
    logic                w_ack;
    logic                w_underflow;
    logic                r_err;

    assign w_req = '{vld:      i_issue_vld,
                     rs1_used: i_issue_rs1_used, rs1_addr: i_issue_rs1_addr,
                     rs2_used: i_issue_rs2_used, rs2_addr: i_issue_rs2_addr,
                     rd_wren:  i_issue_rd_wren,  rd_addr:  i_issue_rd_addr};

    // x0 has no counter: never busy, never full, never hit by writeback.
    assign w_nonzero[0]  = 1'b0;
    assign w_at_max[0]   = 1'b0;
    assign w_wb_hit[0]   = 1'b0;
    assign w_busy_eff[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [CNT_W-1:0] w_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_wb_hit[r] = i_wb_rd_wren && (i_wb_rd_addr == reg_addr_t'(r));
        assign w_inc       = w_ack && w_req.rd_wren && (w_req.rd_addr == reg_addr_t'(r));
        assign w_dec       = w_wb_hit[r] && w_nonzero[r];
        // Last outstanding writer retiring now is bypassed to the reader.
        assign w_busy_eff[r] = w_nonzero[r] && !(w_wb_hit[r] && (w_cnt == CNT_W'(1)));

        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_inc     (w_inc),
            .i_dec     (w_dec),
            .i_clr     (i_flush),
            .o_cnt     (w_cnt),
            .o_nonzero (w_nonzero[r]),
            .o_at_max  (w_at_max[r])
        );
    end

    assign w_src_hz = (w_req.rs1_used && w_busy_eff[w_req.rs1_addr]) ||
                      (w_req.rs2_used && w_busy_eff[w_req.rs2_addr]);
    assign w_ovf    = w_req.rd_wren && (w_req.rd_addr != '0) &&
                      w_at_max[w_req.rd_addr] && !w_wb_hit[w_req.rd_addr];
    assign w_stall  = w_req.vld && !i_flush && (w_src_hz || w_ovf);
    assign w_ack    = w_req.vld && !i_flush && !w_stall;

    assign w_underflow = !i_flush && i_wb_rd_wren && (i_wb_rd_addr != '0) &&
                         !w_nonzero[i_wb_rd_addr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign o_stall     = w_stall;
    assign o_issue_ack = w_ack;
    assign o_busy_vec  = w_nonzero;
    assign o_err       = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table plus randomized traffic against an array-based pending-count model.
module tb_regfile_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_issue_vld, i_issue_rs1_used, i_issue_rs2_used, i_issue_rd_wren;
    logic [4:0]  i_issue_rs1_addr, i_issue_rs2_addr, i_issue_rd_addr;
    logic        i_wb_rd_wren, i_flush;
    logic [4:0]  i_wb_rd_addr;
    logic        o_stall, o_issue_ack, o_err;
    logic [31:0] o_busy_vec;

    int errors = 0;
    int checks = 0;

    int m_cnt[32];
    bit m_err;
    bit m_stall, m_ack;
    logic [31:0] m_busy;

    typedef struct {
        bit fl, vl, r1u; int r1;
        bit r2u; int r2;
        bit rdw; int rd;
        bit wbw; int wba;
        bit es, ea; logic [31:0] eb; bit ee;
    } vec_t;

    vec_t tab[27];

    regfile_scoreboard #(.CNT_W(CNT_W), .NUM_REGS(32)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_issue_vld      (i_issue_vld),
        .i_issue_rs1_used (i_issue_rs1_used),
        .i_issue_rs1_addr (i_issue_rs1_addr),
        .i_issue_rs2_used (i_issue_rs2_used),
        .i_issue_rs2_addr (i_issue_rs2_addr),
        .i_issue_rd_wren  (i_issue_rd_wren),
        .i_issue_rd_addr  (i_issue_rd_addr),
        .i_wb_rd_wren     (i_wb_rd_wren),
        .i_wb_rd_addr     (i_wb_rd_addr),
        .i_flush          (i_flush),
        .o_stall          (o_stall),
        .o_issue_ack      (o_issue_ack),
        .o_busy_vec       (o_busy_vec),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(bit fl, bit vl, bit r1u, int r1, bit r2u, int r2,
                               bit rdw, int rd, bit wbw, int wba,
                               bit es, bit ea, logic [31:0] eb, bit ee);
        vec_t v;
        v.fl = fl; v.vl = vl; v.r1u = r1u; v.r1 = r1; v.r2u = r2u; v.r2 = r2;
        v.rdw = rdw; v.rd = rd; v.wbw = wbw; v.wba = wba;
        v.es = es; v.ea = ea; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_flush          = v.fl;
        i_issue_vld      = v.vl;
        i_issue_rs1_used = v.r1u;
        i_issue_rs1_addr = 5'(v.r1);
        i_issue_rs2_used = v.r2u;
        i_issue_rs2_addr = 5'(v.r2);
        i_issue_rd_wren  = v.rdw;
        i_issue_rd_addr  = 5'(v.rd);
        i_wb_rd_wren     = v.wbw;
        i_wb_rd_addr     = 5'(v.wba);
    endtask

    function automatic bit wb_to(int r);
        return i_wb_rd_wren && (int'(i_wb_rd_addr) == r);
    endfunction

    function automatic bit src_busy(int r);
        return (r != 0) && (m_cnt[r] != 0) && !(wb_to(r) && m_cnt[r] == 1);
    endfunction

    task automatic model_eval();
        bit hz, ovf;
        int rd;
        rd  = int'(i_issue_rd_addr);
        hz  = (i_issue_rs1_used && src_busy(int'(i_issue_rs1_addr))) ||
              (i_issue_rs2_used && src_busy(int'(i_issue_rs2_addr)));
        ovf = i_issue_rd_wren && rd != 0 && m_cnt[rd] == MAXC && !wb_to(rd);
        m_stall = i_issue_vld && !i_flush && (hz || ovf);
        m_ack   = i_issue_vld && !i_flush && !m_stall;
        m_busy  = '0;
        for (int r = 1; r < 32; r++) m_busy[r] = (m_cnt[r] != 0);
    endtask

    task automatic model_update();
        int rd, wa;
        rd = int'(i_issue_rd_addr);
        wa = int'(i_wb_rd_addr);
        if (i_flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            if (i_wb_rd_wren && wa != 0) begin
                if (m_cnt[wa] == 0) m_err = 1'b1;
                else m_cnt[wa] = m_cnt[wa] - 1;
            end
            if (m_ack && i_issue_rd_wren && rd != 0) m_cnt[rd] = m_cnt[rd] + 1;
        end
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = V(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);

        tab[0]  = V(0,1,0,0,0,0,1,5,0,0, 0,1,32'h0,0);
        tab[1]  = V(0,1,1,5,0,0,0,0,0,0, 1,0,32'h20,0);
        tab[2]  = V(0,1,1,5,0,0,0,0,1,5, 0,1,32'h20,0);
        tab[3]  = V(0,1,1,0,0,0,1,0,0,0, 0,1,32'h0,0);
        tab[4]  = V(0,1,1,0,1,0,0,0,0,0, 0,1,32'h0,0);
        tab[5]  = V(0,1,0,0,0,0,1,7,0,0, 0,1,32'h0,0);
        tab[6]  = V(0,1,0,0,0,0,1,7,0,0, 0,1,32'h80,0);
        tab[7]  = V(0,1,0,0,0,0,1,7,0,0, 0,1,32'h80,0);
        tab[8]  = V(0,1,0,0,0,0,1,7,0,0, 1,0,32'h80,0);
        tab[9]  = V(0,1,0,0,0,0,1,7,1,7, 0,1,32'h80,0);
        tab[10] = V(0,1,0,0,0,0,1,7,0,0, 1,0,32'h80,0);
        tab[11] = V(0,0,0,0,0,0,0,0,1,7, 0,0,32'h80,0);
        tab[12] = V(0,0,0,0,0,0,0,0,1,7, 0,0,32'h80,0);
        tab[13] = V(0,0,0,0,0,0,0,0,1,7, 0,0,32'h80,0);
        tab[14] = V(0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0);
        tab[15] = V(0,1,0,0,0,0,1,9,0,0, 0,1,32'h0,0);
        tab[16] = V(0,1,0,0,0,0,1,9,1,9, 0,1,32'h200,0);
        tab[17] = V(0,0,0,0,0,0,0,0,0,0, 0,0,32'h200,0);
        tab[18] = V(0,0,0,0,0,0,0,0,1,9, 0,0,32'h200,0);
        tab[19] = V(0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0);
        tab[20] = V(0,0,0,0,0,0,0,0,1,12, 0,0,32'h0,0);
        tab[21] = V(0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,1);
        tab[22] = V(0,1,0,0,0,0,1,3,0,0, 0,1,32'h0,1);
        tab[23] = V(0,1,0,0,0,0,1,4,0,0, 0,1,32'h8,1);
        tab[24] = V(0,1,0,0,0,0,1,20,0,0, 0,1,32'h18,1);
        tab[25] = V(1,1,0,0,0,0,1,11,1,3, 0,0,32'h100018,1);
        tab[26] = V(0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,1);

        rst_n = 1'b0;
        drive(idle);
        #3;
        check("reset_stall", 32'(o_stall), 32'h0);
        check("reset_ack", 32'(o_issue_ack), 32'h0);
        check("reset_busy", o_busy_vec, 32'h0);
        check("reset_err", 32'(o_err), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(tab[i]);
            #4;
            check($sformatf("row%0d_stall", i), 32'(o_stall), 32'(tab[i].es));
            check($sformatf("row%0d_ack", i), 32'(o_issue_ack), 32'(tab[i].ea));
            check($sformatf("row%0d_busy", i), o_busy_vec, tab[i].eb);
            check($sformatf("row%0d_err", i), 32'(o_err), 32'(tab[i].ee));
            @(posedge clk);
            #1;
        end

        // Async reset while a reader is stalled on x6.
        drive(V(0,1,0,0,0,0,1,6,0,0, 0,0,0,0));
        #4;
        check("pre_rst_ack", 32'(o_issue_ack), 32'h1);
        @(posedge clk);
        #1;
        drive(V(0,1,1,6,0,0,0,0,0,0, 0,0,0,0));
        #4;
        check("pre_rst_stall", 32'(o_stall), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(o_stall), 32'h0);
        check("mid_rst_busy", o_busy_vec, 32'h0);
        check("mid_rst_err", 32'(o_err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Flush suppresses the underflow error of a same-cycle writeback.
        drive(V(1,1,0,0,0,0,1,2,1,12, 0,0,0,0));
        #4;
        check("flush_ack", 32'(o_issue_ack), 32'h0);
        @(posedge clk);
        #1;
        drive(idle);
        #4;
        check("flush_no_err", 32'(o_err), 32'h0);
        check("flush_no_busy", o_busy_vec, 32'h0);
        @(posedge clk);
        #1;

        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            v.fl  = ($urandom_range(0, 31) == 0);
            v.vl  = ($urandom_range(0, 3) != 0);
            v.r1u = 1'($urandom);
            v.r1  = $urandom_range(0, 7);
            v.r2u = 1'($urandom);
            v.r2  = $urandom_range(0, 7);
            v.rdw = ($urandom_range(0, 3) != 0);
            v.rd  = $urandom_range(0, 5);
            v.wbw = ($urandom_range(0, 2) == 0);
            v.wba = $urandom_range(0, 5);
            drive(v);
            #4;
            model_eval();
            check($sformatf("rnd%0d_stall", n), 32'(o_stall), 32'(m_stall));
            check($sformatf("rnd%0d_ack", n), 32'(o_issue_ack), 32'(m_ack));
            check($sformatf("rnd%0d_busy", n), o_busy_vec, m_busy);
            check($sformatf("rnd%0d_err", n), 32'(o_err), 32'(m_err));
            @(posedge clk);
            model_update();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
